// File: rtl/modexp_pixel_encryptor_if.sv
// Handshake bundle for the modular-exponentiation pixel engine.
// The slave side is the engine; the master side is the pixel source plus the memory writer.
interface modexp_pixel_encryptor_if #(
    parameter int W  = 16,
    parameter int EW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  msg;
    logic [EW-1:0] exp;
    logic [W-1:0]  modulus;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  cipher;
    logic          err;

    modport master (
        output in_valid, msg, exp, modulus, out_ready,
        input  in_ready, out_valid, cipher, err
    );

    modport slave (
        input  in_valid, msg, exp, modulus, out_ready,
        output in_ready, out_valid, cipher, err
    );
endinterface

// File: rtl/modexp_pixel_encryptor.sv
// Sequential C = M^E mod N engine using right-to-left square-and-multiply.
// It processes one exponent bit per clock, with a fixed EW-cycle latency and valid/ready on both sides.
module modexp_pixel_encryptor #(
    parameter int W  = 16,
    parameter int EW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    modexp_pixel_encryptor_if.slave bus
);
    localparam int DW = 2 * W;
    localparam int CW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [W-1:0]  base_q;
    logic [W-1:0]  res_q;
    logic [EW-1:0] e_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  mod_q;
    logic [W-1:0]  cipher_q;
    logic          err_q;
    logic          out_valid_q;

    logic [W-1:0]  mod_safe;
    logic [W-1:0]  in_mod_safe;
    logic [W-1:0]  msg_red;
    logic [DW-1:0] res_prod;
    logic [DW-1:0] base_prod;
    logic [W-1:0]  res_next;
    logic [W-1:0]  base_next;
    logic          in_mod_ok;

    // Divisors are forced to 1 when N < 2. This keeps the datapath free of divide-by-zero
    // while the result is unused anyway.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mod_safe    = (mod_q < W'(2)) ? W'(1) : mod_q;
        in_mod_ok   = (bus.modulus >= W'(2));
        in_mod_safe = in_mod_ok ? bus.modulus : W'(1);
        msg_red     = bus.msg % in_mod_safe;
        res_prod    = DW'(res_q) * DW'(base_q);
        base_prod   = DW'(base_q) * DW'(base_q);
        res_next    = e_q[0] ? W'(res_prod % DW'(mod_safe)) : res_q;
        base_next   = W'(base_prod % DW'(mod_safe));
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    // NOTE: every register, including the datapath ones, is cleared by the async reset.
    // This means an aborted job leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            res_q       <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            mod_q       <= '0;
            cipher_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mod_q <= bus.modulus;
                        if (in_mod_ok) begin
                            base_q  <= msg_red;
                            res_q   <= W'(1);
                            e_q     <= bus.exp;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            cipher_q <= '0;
                            err_q    <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                RUN: begin
                    res_q  <= res_next;
                    base_q <= base_next;
                    e_q    <= e_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(EW - 1)) begin
                        cipher_q    <= res_next;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // The error path arrives here without out_valid set, so it is raised one edge later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.cipher    = cipher_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_modexp_pixel_encryptor.sv
// Self-checking bench for modexp_pixel_encryptor, covering table vectors, handshake corner cases
// and random jobs checked against a naive repeated-multiply model.
module tb_modexp_pixel_encryptor;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    modexp_pixel_encryptor_if #(.W(16), .EW(16)) bus ();

    modexp_pixel_encryptor #(.W(16), .EW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] n;
        logic [15:0] c;
        logic        er;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference uses plain repeated multiplication, not square-and-multiply.
    function automatic void model(input longint m, input longint e, input longint n,
                                  output longint c, output bit er);
        longint r;
        if (n < 2) begin
            c  = 0;
            er = 1'b1;
        end else begin
            r = 1;
            for (longint i = 0; i < e; i++) r = (r * (m % n)) % n;
            c  = r;
            er = 1'b0;
        end
    endfunction

    task automatic run_job(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                           output logic [15:0] c, output logic er, output int lat, output bit ok);
        int guard;
        ok  = 1'b0;
        lat = 0;
        c   = '0;
        er  = 1'b0;
        @(negedge clk);
        bus.msg      = m;
        bus.exp      = e;
        bus.modulus  = n;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.msg      = 16'($urandom);
        bus.exp      = 16'($urandom);
        bus.modulus  = 16'($urandom);
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        ok = bus.out_valid;
        c  = bus.cipher;
        er = bus.err;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic job_and_check(input string tag, input logic [15:0] m, input logic [15:0] e,
                                 input logic [15:0] n, input logic [15:0] c_req, input logic er_req);
        logic [15:0] c;
        logic        er;
        int          lat;
        bit          ok;
        run_job(m, e, n, c, er, lat, ok);
        check({tag, " completed"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, " cipher"}, 32'(c), 32'(c_req));
            check({tag, " err"}, 32'(er), 32'(er_req));
            check({tag, " latency"}, 32'(lat), er_req ? 32'd1 : 32'd16);
            check({tag, " out_valid dropped"}, 32'(bus.out_valid), 32'd0);
            check({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        int     hits;
        longint mc;
        bit     mer;
        logic [15:0] rm, re, rn;
        int     guard;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.msg       = '0;
        bus.exp       = '0;
        bus.modulus   = '0;

        vecs[0]  = '{16'd65,    16'd17,    16'd3233,  16'd2790,  1'b0};
        vecs[1]  = '{16'd2790,  16'd2753,  16'd3233,  16'd65,    1'b0};
        vecs[2]  = '{16'd123,   16'd0,     16'd3233,  16'd1,     1'b0};
        vecs[3]  = '{16'd5000,  16'd1,     16'd3233,  16'd1767,  1'b0};
        vecs[4]  = '{16'd77,    16'd999,   16'd1,     16'd0,     1'b1};
        vecs[5]  = '{16'd65,    16'd17,    16'd3233,  16'd2790,  1'b0};
        vecs[6]  = '{16'd5,     16'd3,     16'd0,     16'd0,     1'b1};
        vecs[7]  = '{16'd0,     16'd5,     16'd3233,  16'd0,     1'b0};
        vecs[8]  = '{16'd65535, 16'd65535, 16'd65535, 16'd0,     1'b0};
        vecs[9]  = '{16'd2,     16'd15,    16'd65535, 16'd32768, 1'b0};
        vecs[10] = '{16'd3,     16'd2,     16'd2,     16'd1,     1'b0};
        vecs[11] = '{16'd65534, 16'd2,     16'd65535, 16'd1,     1'b0};

        #12;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset cipher", 32'(bus.cipher), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            job_and_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].n,
                          vecs[i].c, vecs[i].er);
        end

        // Back-pressure: result held for 5 cycles while the source toggles in_valid.
        @(negedge clk);
        bus.msg = 16'd65; bus.exp = 16'd17; bus.modulus = 16'd3233; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(posedge clk);
            guard++;
            #1;
        end
        check("bp out_valid rose", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.msg      = 16'($urandom);
            #1;
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
            check("bp cipher held", 32'(bus.cipher), 32'd2790);
            check("bp in_ready low", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp handshake out_valid", 32'(bus.out_valid), 32'd0);
        check("bp handshake in_ready", 32'(bus.in_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) hits++;
        end
        check("bp nothing accepted", 32'(hits), 32'd0);
        check("bp cipher kept in idle", 32'(bus.cipher), 32'd2790);

        // Reset during RUN cycle 7 aborts the job.
        @(negedge clk);
        bus.msg = 16'd1234; bus.exp = 16'd4321; bus.modulus = 16'd3233; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) hits++;
        end
        check("midrst no out_valid", 32'(hits), 32'd0);
        job_and_check("after reset", 16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);

        // Random jobs against the reference model; some use tiny moduli to hit the error path.
        for (int i = 0; i < 24; i++) begin
            rm = 16'($urandom);
            re = 16'($urandom);
            rn = (i % 6 == 5) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            model(longint'(rm), longint'(re), longint'(rn), mc, mer);
            job_and_check($sformatf("rand%0d m=%0d e=%0d n=%0d", i, rm, re, rn),
                          rm, re, rn, 16'(mc), mer);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
